// File: rtl/byte_deint_pkg.sv
// byte_deint_pkg: shared state encodings, column count and RS info-length lookup for the de-interleaver
package byte_deint_pkg;
  localparam int NCOL = 240;
  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_t;
  typedef enum logic [1:0] {W_IDLE, W_ARM, W_WR} wr_t;
  typedef enum logic [1:0] {R_IDLE, R_RD, R_FLUSH} rd_t;
  function automatic logic [7:0] rs_k_m1(input logic [1:0] mode);
    return mode == 2'd0 ? 8'd239 : mode == 2'd1 ? 8'd223 : mode == 2'd2 ? 8'd191 : 8'd175;
  endfunction
endpackage

// File: rtl/byte_deint_ofifo.sv
// byte_deint_ofifo: 2-entry valid/ready output FIFO with occupancy count
module byte_deint_ofifo #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic wp, rp, pop;
  assign valid = count != 2'd0;
  assign pop = valid && ready;
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mem <= '{default: '0};
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= !wp;
      end
      if (pop) rp <= !rp;
      count <= count + 2'(push) - 2'(pop);
    end
endmodule

// File: rtl/byte_deint_pp.sv
// byte_deint_pp: ping-pong byte de-interleaver buffer with parity-column strip and valid/ready TS output
module byte_deint_pp #(
  parameter int MAX_ROW = 432,
  parameter int MAX_SLOT = 8,
  parameter int NCOL = byte_deint_pkg::NCOL,
  parameter int RW = 9,
  parameter int SW = 4,
  parameter int AW = 21
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          byte_sync,
  input  logic          byte_win,
  input  logic [7:0]    byte_data,
  input  logic          slot_ini,
  input  logic [RW-1:0] row_m1,
  input  logic [SW-1:0] slot_num,
  input  logic [1:0]    rs_mode,
  output logic          mem_we,
  output logic [AW-1:0] mem_wa,
  output logic [7:0]    mem_wd,
  output logic          mem_re,
  output logic [AW-1:0] mem_ra,
  input  logic [7:0]    mem_rd,
  output logic          ts_valid,
  input  logic          ts_ready,
  output logic [7:0]    ts_data,
  output logic          ts_last,
  output logic          ts_int,
  output logic          ts_overflow
);
  import byte_deint_pkg::*;
  localparam int OW = AW - 1;
  localparam int CW = $clog2(NCOL);
  bank_t bank_st [2];
  bank_t bank_nx [2];
  wr_t wr_state, wr_nx;
  rd_t rd_state, rd_nx;
  logic wb, rb;
  logic [RW-1:0] cfg_row [2];
  logic [SW-1:0] cfg_slot [2];
  logic [7:0] cfg_k [2];
  logic [OW-1:0] cfg_stride [2];
  logic [RW-1:0] row_in;
  logic [SW-1:0] slot_in;
  logic wb_free, arm, acc, w_last, w_done, r_start, r_last, rel, pop;
  logic [RW-1:0] wrow, rrow;
  logic [CW-1:0] wcol;
  logic [7:0] rcol;
  logic [SW-1:0] wslot, rslot;
  logic [OW-1:0] woff, roff, rbase;
  logic rd_pend, last_pend;
  logic [1:0] fifo_cnt;
  logic [8:0] fifo_q;
  assign row_in = row_m1 > RW'(MAX_ROW - 1) ? RW'(MAX_ROW - 1) : row_m1;
  assign slot_in = slot_num == '0 ? SW'(1) : slot_num > SW'(MAX_SLOT) ? SW'(MAX_SLOT) : slot_num;
  assign rel = rd_state == R_FLUSH && fifo_cnt == 2'd0 && !rd_pend;
  assign wb_free = bank_st[wb] == B_EMPTY || bank_st[wb] == B_FILLING || (rel && rb == wb);
  assign arm = slot_ini && wb_free;
  assign acc = byte_sync && byte_win && wr_state != W_IDLE && !slot_ini;
  assign w_last = wrow == cfg_row[wb] && wcol == CW'(NCOL - 1) && wslot == cfg_slot[wb] - SW'(1);
  assign w_done = acc && w_last;
  assign r_start = rd_state == R_IDLE && bank_st[rb] == B_FULL;
  assign pop = ts_valid && ts_ready;
  assign mem_re = rd_state == R_RD && (3'(fifo_cnt) + 3'(rd_pend) - 3'(pop)) < 3'd2;
  assign r_last = rrow == cfg_row[rb] && rcol == cfg_k[rb] && rslot == cfg_slot[rb] - SW'(1);
  assign mem_ra = {rb, roff};
  assign ts_last = fifo_q[8];
  assign ts_data = fifo_q[7:0];
  always_comb begin
    bank_nx = bank_st;
    if (rel) bank_nx[rb] = B_EMPTY;
    if (r_start) bank_nx[rb] = B_DRAINING;
    if (w_done) bank_nx[wb] = B_FULL;
    if (arm) bank_nx[wb] = B_FILLING;
  end
  always_comb wr_nx = arm ? W_ARM : w_done ? W_IDLE : acc ? W_WR : wr_state;
  always_comb rd_nx = r_start ? R_RD : (mem_re && r_last) ? R_FLUSH : rel ? R_IDLE : rd_state;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
      bank_st <= '{default: B_EMPTY};
      wb <= 1'b0;
      rb <= 1'b0;
    end else begin
      wr_state <= wr_nx;
      rd_state <= rd_nx;
      bank_st <= bank_nx;
      wb <= wb ^ w_done;
      rb <= rb ^ rel;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cfg_row <= '{default: '0};
      cfg_slot <= '{default: '0};
      cfg_k <= '{default: '0};
      cfg_stride <= '{default: '0};
    end else if (arm) begin
      cfg_row[wb] <= row_in;
      cfg_slot[wb] <= slot_in;
      cfg_k[wb] <= rs_k_m1(rs_mode);
      cfg_stride[wb] <= OW'((int'(row_in) + 1) * NCOL);
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wrow <= '0;
      wcol <= '0;
      wslot <= '0;
      woff <= '0;
      mem_we <= 1'b0;
      mem_wa <= '0;
      mem_wd <= '0;
      ts_int <= 1'b0;
      ts_overflow <= 1'b0;
    end else begin
      if (arm) begin
        wrow <= '0;
        wcol <= '0;
        wslot <= '0;
        woff <= '0;
      end else if (acc) begin
        woff <= woff + OW'(1);
        wrow <= wrow == cfg_row[wb] ? '0 : wrow + RW'(1);
        if (wrow == cfg_row[wb]) begin
          wcol <= wcol == CW'(NCOL - 1) ? '0 : wcol + CW'(1);
          wslot <= wslot + SW'(wcol == CW'(NCOL - 1));
        end
      end
      mem_we <= acc;
      if (acc) begin
        mem_wa <= {wb, woff};
        mem_wd <= byte_data;
      end
      ts_int <= w_done;
      ts_overflow <= slot_ini && !wb_free;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rrow <= '0;
      rcol <= '0;
      rslot <= '0;
      roff <= '0;
      rbase <= '0;
      rd_pend <= 1'b0;
      last_pend <= 1'b0;
    end else begin
      if (r_start) begin
        rrow <= '0;
        rcol <= '0;
        rslot <= '0;
        roff <= '0;
        rbase <= '0;
      end else if (mem_re) begin
        if (rrow != cfg_row[rb]) begin
          rrow <= rrow + RW'(1);
          roff <= roff + OW'(1);
        end else if (rcol != cfg_k[rb]) begin
          rrow <= '0;
          rcol <= rcol + 8'd1;
          roff <= roff + OW'(1);
        end else begin
          rrow <= '0;
          rcol <= '0;
          rslot <= rslot + SW'(1);
          rbase <= rbase + cfg_stride[rb];
          roff <= rbase + cfg_stride[rb];
        end
      end
      rd_pend <= mem_re;
      last_pend <= mem_re && r_last;
    end
  byte_deint_ofifo #(.W(9)) u_ofifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(rd_pend),
    .din({last_pend, mem_rd}),
    .valid(ts_valid),
    .ready(ts_ready),
    .dout(fifo_q),
    .count(fifo_cnt)
  );
endmodule

// File: tb/tb_byte_deint_pp.sv
// tb_byte_deint_pp: randomized self-checking bench for the ping-pong byte de-interleaver
module tb_byte_deint_pp;
  localparam int RW = 9;
  localparam int SW = 4;
  localparam int AW = 21;
  localparam int NC = 240;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic byte_sync = 1'b0;
  logic byte_win = 1'b0;
  logic [7:0] byte_data = 8'd0;
  logic slot_ini = 1'b0;
  logic [RW-1:0] row_m1 = '0;
  logic [SW-1:0] slot_num = SW'(1);
  logic [1:0] rs_mode = 2'd0;
  logic mem_we, mem_re, ts_valid, ts_last, ts_int, ts_overflow;
  logic [AW-1:0] mem_wa, mem_ra;
  logic [7:0] mem_wd, ts_data;
  logic [7:0] mem_rd = 8'd0;
  logic ts_ready = 1'b0;
  logic [7:0] mem_arr [0:(1<<AW)-1];
  logic [7:0] in_q [$];
  logic [8:0] exp_q [$];
  logic [8:0] out_q [$];
  int n_tests = 0;
  int n_fail = 0;
  int n_int = 0;
  int n_ovf = 0;
  int ready_mode = 0;
  bit both_seen = 1'b0;
  bit stall = 1'b0;
  logic [8:0] held = '0;
  logic [7:0] b8640;
  int kinfo [4] = '{240, 224, 192, 176};
  byte_deint_pp dut (
    .clk(clk), .reset_n(reset_n), .byte_sync(byte_sync), .byte_win(byte_win),
    .byte_data(byte_data), .slot_ini(slot_ini), .row_m1(row_m1), .slot_num(slot_num),
    .rs_mode(rs_mode), .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .mem_re(mem_re), .mem_ra(mem_ra), .mem_rd(mem_rd), .ts_valid(ts_valid),
    .ts_ready(ts_ready), .ts_data(ts_data), .ts_last(ts_last), .ts_int(ts_int),
    .ts_overflow(ts_overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_wa] <= mem_wd;
    if (mem_re) mem_rd <= mem_arr[mem_ra];
  end
  function automatic logic [63:0] outs();
    return {mem_we, mem_wa, mem_wd, mem_re, mem_ra, ts_valid, ts_data, ts_last, ts_int, ts_overflow};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    ts_ready = ready_mode == 2 ? 1'($urandom_range(0, 1)) : ready_mode == 1;
  end
  always @(negedge clk) begin
    if (stall && reset_n) chk("stable while stalled", {ts_valid, ts_last, ts_data}, {1'b1, held});
    stall = ts_valid && !ts_ready && reset_n;
    held = {ts_last, ts_data};
    if (ts_valid && ts_ready) out_q.push_back({ts_last, ts_data});
    n_int += int'(ts_int);
    n_ovf += int'(ts_overflow);
    if (mem_we && mem_re) both_seen = 1'b1;
  end
  task automatic arm(input int rm1, input int sn, input int mode);
    slot_ini = 1'b1;
    row_m1 = RW'(rm1);
    slot_num = SW'(sn);
    rs_mode = 2'(mode);
    tick();
    slot_ini = 1'b0;
  endtask
  task automatic feed(input int n, input bit ramp, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        byte_sync = $urandom_range(0, 1) == 1;
        byte_win = !byte_sync;
        byte_data = 8'($urandom);
        tick();
      end
      byte_sync = 1'b1;
      byte_win = 1'b1;
      byte_data = ramp ? 8'(i) : 8'($urandom);
      in_q.push_back(byte_data);
      tick();
    end
    byte_sync = 1'b0;
    byte_win = 1'b0;
  endtask
  task automatic expect_frame(input int rm1, input int sn, input int mode);
    int r = rm1 + 1;
    for (int s = 0; s < sn; s++)
      for (int c = 0; c < kinfo[mode]; c++)
        for (int rr = 0; rr < r; rr++)
          exp_q.push_back({1'(s == sn - 1 && c == kinfo[mode] - 1 && rr == r - 1), in_q[s * r * NC + c * r + rr]});
    in_q.delete();
  endtask
  task automatic drain(input string tag, input int budget);
    int cyc = 0;
    int bad = -1;
    while (out_q.size() < exp_q.size() && cyc < budget) begin
      tick();
      cyc++;
    end
    repeat (8) tick();
    chk({tag, " byte count"}, 64'(out_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && out_q[i] !== exp_q[i]) bad = i;
    chk({tag, " first bad {index,byte}"}, bad < 0 ? 64'(0) : 64'({bad, out_q[bad]}), bad < 0 ? 64'(0) : 64'({bad, exp_q[bad]}));
  endtask
  task automatic clear();
    out_q.delete();
    exp_q.delete();
    in_q.delete();
  endtask
  initial begin
    int m;
    repeat (3) tick();
    chk("reset outputs", outs(), 64'(0));
    reset_n = 1'b1;
    tick();
    ready_mode = 1;
    n_int = 0;
    arm(35, 1, 0);
    feed(8640, 1'b1, 1'b0);
    expect_frame(35, 1, 0);
    drain("single frame", 20000);
    chk("single frame ts_int count", 64'(n_int), 64'(1));
    clear();
    n_int = 0;
    arm(35, 2, 3);
    feed(17280, 1'b0, 1'b0);
    b8640 = in_q[8640];
    expect_frame(35, 2, 3);
    drain("parity strip", 30000);
    chk("parity strip slot1 head", 64'(out_q.size() > 6336 ? out_q[6336][7:0] : 8'hxx), 64'(b8640));
    clear();
    n_int = 0;
    n_ovf = 0;
    both_seen = 1'b0;
    arm(3, 1, 0);
    feed(960, 1'b0, 1'b1);
    expect_frame(3, 1, 0);
    arm(3, 1, 1);
    feed(960, 1'b0, 1'b1);
    expect_frame(3, 1, 1);
    drain("ping-pong", 6000);
    chk("ping-pong concurrent write/read", 64'(both_seen), 64'(1));
    chk("ping-pong overflow count", 64'(n_ovf), 64'(0));
    chk("ping-pong ts_int count", 64'(n_int), 64'(2));
    clear();
    ready_mode = 0;
    tick();
    n_int = 0;
    n_ovf = 0;
    arm(1, 1, 1);
    feed(480, 1'b0, 1'b0);
    expect_frame(1, 1, 1);
    arm(1, 1, 2);
    feed(480, 1'b0, 1'b0);
    expect_frame(1, 1, 2);
    repeat (4) tick();
    chk("overflow before third arm", 64'(n_ovf), 64'(0));
    arm(1, 1, 0);
    tick();
    chk("overflow after third arm", 64'(n_ovf), 64'(1));
    feed(100, 1'b0, 1'b0);
    in_q.delete();
    ready_mode = 1;
    drain("overflow frames", 6000);
    chk("overflow ts_int count", 64'(n_int), 64'(2));
    clear();
    ready_mode = 2;
    n_int = 0;
    m = $urandom_range(0, 3);
    arm(4, 2, m);
    feed(2400, 1'b0, 1'b1);
    expect_frame(4, 2, m);
    drain("backpressure", 20000);
    clear();
    ready_mode = 1;
    n_int = 0;
    arm(3, 2, 0);
    feed(500, 1'b0, 1'b0);
    in_q.delete();
    arm(2, 1, 2);
    feed(720, 1'b0, 1'b0);
    expect_frame(2, 1, 2);
    drain("abort re-arm", 6000);
    chk("abort ts_int count", 64'(n_int), 64'(1));
    clear();
    arm(9, 1, 0);
    feed(2400, 1'b0, 1'b0);
    in_q.delete();
    for (int i = 0; i < 5000 && out_q.size() < 50; i++) tick();
    chk("drain started before reset", 64'(out_q.size() >= 50), 64'(1));
    reset_n = 1'b0;
    #2;
    chk("reset mid-drain outputs", outs(), 64'(0));
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    clear();
    n_int = 0;
    arm(2, 1, 0);
    feed(720, 1'b0, 1'b1);
    expect_frame(2, 1, 0);
    drain("after reset", 6000);
    chk("after reset ts_int count", 64'(n_int), 64'(1));
    clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
